// File: rtl/eq_pkg.sv
// Shared types and widths for the equalizer magnitude paths.
// Holds the square-root scheduler FSM state type and default operand/result widths.
package eq_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} sqrt_state_t;

  localparam int SQRT_MAG_W = 16;
  localparam int SQRT_RES_W = 8;

endpackage

// File: rtl/sqrt_iter.sv
// Bit-serial floor(sqrt) engine: loads the operand on i_start, then resolves one result bit per cycle, MSB first.
// o_res carries the final result in the cycle o_done pulses.
module sqrt_iter
  import eq_pkg::*;
#(
  parameter int MAG_W = SQRT_MAG_W,
  parameter int RES_W = SQRT_RES_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [MAG_W-1:0] i_mag,
  output logic [RES_W-1:0] o_res,
  output logic             o_done,
  output logic             o_busy
);

  localparam logic [RES_W-1:0] BIT_MSB = {1'b1, {(RES_W-1){1'b0}}};

  logic [MAG_W-1:0] r_mag;
  logic [RES_W-1:0] r_res;
  logic [RES_W-1:0] r_bit;
  logic             r_busy;

  logic [RES_W-1:0] w_trial;
  logic [MAG_W-1:0] w_sq;
  logic [RES_W-1:0] w_res_nxt;

  // Square is formed at the full operand width, so it can never wrap.
  assign w_trial   = r_res | r_bit;
  assign w_sq      = MAG_W'(w_trial) * MAG_W'(w_trial);
  assign w_res_nxt = (w_sq <= r_mag) ? w_trial : r_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag  <= '0;
      r_res  <= '0;
      r_bit  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_mag  <= i_mag;
      r_res  <= '0;
      r_bit  <= BIT_MSB;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_res <= w_res_nxt;
      r_bit <= r_bit >> 1;
      if (r_bit[0]) r_busy <= 1'b0;
    end
  end

  assign o_res  = w_res_nxt;
  assign o_done = r_busy & r_bit[0];
  assign o_busy = r_busy;

endmodule

// File: rtl/sqrt_sched.sv
// Round-robin arbiter sharing one sqrt_iter among NUM_REQ magnitude requesters.
// Grants in IDLE, waits for the engine in CALC, pulses a one-hot ack in DONE.
module sqrt_sched
  import eq_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAG_W   = SQRT_MAG_W,
  parameter int RES_W   = SQRT_RES_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*MAG_W-1:0]   mag_in,
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] ack_id,
  output logic [RES_W-1:0]           sqrt_out,
  output logic                       busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  sqrt_state_t      r_state, w_state_nxt;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [NUM_REQ-1:0] r_ack;
  logic [ID_W-1:0]  r_ack_id;
  logic [RES_W-1:0] r_sqrt_out;

  logic             w_found;
  logic [ID_W-1:0]  w_grant_id;
  logic [MAG_W-1:0] w_grant_mag;
  logic             w_start;
  logic [RES_W-1:0] w_res;
  logic             w_done;
  logic             w_iter_busy;

  // Scan starts just past the last granted requester, wrapping around.
  always_comb begin : arb
    int v_idx;
    v_idx       = 0;
    w_found     = 1'b0;
    w_grant_id  = '0;
    w_grant_mag = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && req[v_idx]) begin
        w_found     = 1'b1;
        w_grant_id  = ID_W'(v_idx);
        w_grant_mag = mag_in[v_idx*MAG_W +: MAG_W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_start     = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC:    if (w_done) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Results are registered on entry to DONE so ack is high for the whole DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id       <= '0;
      r_rr_ptr   <= ID_W'(NUM_REQ - 1);
      r_ack      <= '0;
      r_ack_id   <= '0;
      r_sqrt_out <= '0;
    end else begin
      r_ack <= '0;
      if (w_start) r_id <= w_grant_id;
      if (r_state == CALC && w_done) begin
        r_ack      <= NUM_REQ'(1) << r_id;
        r_ack_id   <= r_id;
        r_rr_ptr   <= r_id;
        r_sqrt_out <= w_res;
      end
    end
  end

  sqrt_iter #(
    .MAG_W(MAG_W),
    .RES_W(RES_W)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(w_start),
    .i_mag  (w_grant_mag),
    .o_res  (w_res),
    .o_done (w_done),
    .o_busy (w_iter_busy)
  );

  assign ack      = r_ack;
  assign ack_id   = r_ack_id;
  assign sqrt_out = r_sqrt_out;
  assign busy     = rst_n & ((r_state == IDLE && w_found) || w_iter_busy || r_state == DONE);

endmodule

// File: tb/tb_sqrt_sched.sv
// Directed bench for sqrt_sched: latency, boundary operands, round-robin order, fairness, async reset, operand sweep.
module tb_sqrt_sched;

  localparam int N  = 4;
  localparam int MW = 16;
  localparam int RW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*MW-1:0] mag_in = '0;
  logic [N-1:0]    ack;
  logic [1:0]      ack_id;
  logic [RW-1:0]   sqrt_out;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sqrt_sched #(.NUM_REQ(N), .MAG_W(MW), .RES_W(RW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mag_in  (mag_in),
    .ack     (ack),
    .ack_id  (ack_id),
    .sqrt_out(sqrt_out),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int isqrt(input int m);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= m) r++;
    return r;
  endfunction

  task automatic wait_ack(input int tog_idx, output int n);
    n = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 3 && tog_idx >= 0) mag_in[tog_idx*MW +: MW] = ~mag_in[tog_idx*MW +: MW];
      if (ack != '0) begin
        n = c;
        break;
      end
    end
    if (n == 0) n = 25;
  endtask

  task automatic one(input int id, input int m, input bit tog, input string tag);
    int n;
    req[id] = 1'b1;
    mag_in[id*MW +: MW] = MW'(m);
    wait_ack(tog ? id : -1, n);
    check({tag, "_lat"}, n, 10);
    check({tag, "_ack"}, ack, 32'(1 << id));
    check({tag, "_id"}, ack_id, id);
    check({tag, "_res"}, sqrt_out, isqrt(m));
    tick();
    req[id] = 1'b0;
  endtask

  initial begin
    int n, bcnt, e, prev, seen;
    int bvals[8];
    int order[6];
    bvals = '{0, 1, 3, 4, 15, 16, 65024, 65025};
    order = '{0, 1, 3, 0, 1, 3};

    @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_ack_id", ack_id, 0);
    check("rst_sqrt", sqrt_out, 0);
    check("rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single requester, full-scale operand
    req[0] = 1'b1;
    mag_in[0 +: MW] = 16'hFFFF;
    n = 25;
    bcnt = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (ack != '0) begin
        n = c;
        break;
      end
    end
    check("t1_lat", n, 10);
    check("t1_busy_cycles", bcnt, 10);
    check("t1_ack", ack, 1);
    check("t1_id", ack_id, 0);
    check("t1_res", sqrt_out, 255);
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    check("t1_ack_pulse", ack, 0);
    check("t1_busy_low", busy, 0);
    check("t1_res_held", sqrt_out, 255);
    tick();

    for (int i = 0; i < 8; i++) one(1, bvals[i], 1'b0, $sformatf("t2_%0d", bvals[i]));

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = '1;
    for (int i = 0; i < N; i++) mag_in[i*MW +: MW] = MW'(100 * (i + 1) * (i + 1));
    for (int k = 0; k < N; k++) begin
      wait_ack(-1, n);
      check($sformatf("t3_lat_%0d", k), n, 10);
      check($sformatf("t3_ack_%0d", k), ack, 32'(1 << k));
      check($sformatf("t3_id_%0d", k), ack_id, k);
      check($sformatf("t3_res_%0d", k), sqrt_out, 10 * (k + 1));
      tick();
      req[k] = 1'b0;
    end

    // req[1] held continuously; req[0] and req[3] dropped and re-raised after each ack
    req = 4'b1011;
    mag_in[0*MW +: MW] = 16'd49;
    mag_in[1*MW +: MW] = 16'd81;
    mag_in[3*MW +: MW] = 16'd144;
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      e = order[k];
      wait_ack(-1, n);
      check($sformatf("t4_lat_%0d", k), n < 25, 1);
      check($sformatf("t4_order_%0d", k), ack_id, e);
      check($sformatf("t4_ack_%0d", k), ack, 32'(1 << e));
      check($sformatf("t4_res_%0d", k), sqrt_out, (e == 0) ? 7 : (e == 1) ? 9 : 12);
      check($sformatf("t4_no_repeat_%0d", k), (prev == 1) && (ack_id == 2'd1), 0);
      prev = ack_id;
      tick();
      if (k == 5) begin
        req = '0;
      end else if (e != 1) begin
        req[e] = 1'b0;
        tick();
        req[e] = 1'b1;
      end
    end

    // Reset asserted in the 5th CALC cycle of a grant to requester 0
    req[0] = 1'b1;
    mag_in[0 +: MW] = 16'd1000;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_ack", ack, 0);
    check("t5_ack_id", ack_id, 0);
    check("t5_sqrt", sqrt_out, 0);
    check("t5_busy", busy, 0);
    req[0] = 1'b0;
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (ack != '0) seen++;
    end
    check("t5_no_ack", seen, 0);
    check("t5_sqrt_zero", sqrt_out, 0);
    tick();
    one(2, 2500, 1'b0, "t5_after");

    // Operands around every perfect square plus random ones, toggling mag_in during CALC
    for (int r = 0; r < 256; r++) begin
      one(2, r * r, 1'b1, $sformatf("t6_sq_%0d", r * r));
      if (r > 0) one(2, r * r - 1, 1'b1, $sformatf("t6_sqm1_%0d", r * r - 1));
    end
    one(2, 65535, 1'b1, "t6_max");
    for (int i = 0; i < 150; i++) begin
      e = int'($urandom_range(0, 65535));
      one(2, e, 1'b1, $sformatf("t6_rnd_%0d", e));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
